snake_score: RTL and testbench
==============================

Name: snake_score

Overview:
- Game-score counter and game-state controller for the snake game.
- Counts apple-eaten events, saturates at a configurable maximum, and freezes on collision.
- Drives the 7-bit score code consumed by the score-to-two-digit 7-segment transcoder directly downstream.
- Score is presented pre-shifted: code = score << 2, so bits [1:0] are always 0.

Parameters:
- MAX_SCORE, 31, winning score (legal 1..31); reaching it ends the game in WIN.
- APPLE_POINTS, 1, points added per apple event (legal 1..MAX_SCORE).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  level; sampled each clock; starts or restarts a game.
- apple  input  1  level from the game logic; each 0->1 transition is one apple event.
- collision  input  1  level; high ends the current game.
- score_code  output  7  {score[4:0], 2'b00} to the transcoder.
- running  output  1  high in RUN.
- game_over  output  1  high in OVER.
- win  output  1  high in WIN.

Behaviour:
- Reset state:
  - While rst_n=0: state=IDLE, score=0, apple_q=0.
  - Outputs: score_code=7'b0000000, running=0, game_over=0, win=0.
  - Reset asserted mid-game clears everything immediately, without waiting for a clock edge.
- Edge detect: apple_q is registered every clock in every state. rise = apple & ~apple_q. A level held high counts once.
- FSM states: IDLE, RUN, OVER, WIN (2-bit encoding, registered).
  - IDLE: start=1 -> RUN with score=0. Otherwise hold. apple and collision are ignored.
  - RUN, checked in this priority order:
    1. collision=1 -> OVER, score frozen.
    2. Else rise=1 -> add APPLE_POINTS. If the sum is >= MAX_SCORE, score=MAX_SCORE and go to WIN; otherwise stay in RUN with the new score.
    3. start is ignored in RUN.
  - OVER / WIN: hold score. start=1 -> RUN with score=0. apple and collision are ignored.
- Simultaneous events:
  - collision and rise on the same edge -> collision wins; the apple is not counted.
  - start together with collision in OVER/WIN -> restart; collision is evaluated on the next cycle.
- Latency: an apple rise sampled at edge k produces the new score_code after edge k. Flags change on the same edge as the state.
- Arithmetic:
  - Internal sum is 6 bits wide (score + APPLE_POINTS), so it cannot wrap.
  - score is 5 bits and never exceeds MAX_SCORE.
  - score_code[1:0] are hard-wired 0, so the downstream transcoder never receives an unmapped code.
- All outputs are registered or decoded directly from registered state. No combinational path from inputs to outputs.

Optional Feature:
- Macro: SNAKE_SCORE_HIGH_SCORE_EN.
- Defined:
  - Adds a 5-bit best register, reset to 0.
  - On every transition into OVER or WIN, best is updated if the final score > best. best survives restarts and is cleared only by rst_n.
  - Adds input show_best (1). When show_best=1 in IDLE, OVER or WIN, score_code = {best, 2'b00}. In RUN the live score is always shown.
- Not defined: no best register and no show_best port. score_code always carries the live score.

Test Plan:
1. Reset then start pulse -> running=1, score_code=7'b0000000. Three separate apple pulses -> score_code=7'b0001100 (3), one cycle after each rise.
2. apple held high for 10 cycles in RUN -> exactly one increment, 0 -> 4 (score 1).
3. With MAX_SCORE=31, 31 apple pulses -> score_code=7'b1111100 and win=1. A further apple leaves score_code unchanged. start -> running=1, score_code=0.
4. collision and apple rise on the same edge at score 5 -> game_over=1, score_code=7'b0010100. Later apples and collisions cause no change.
5. rst_n driven low asynchronously mid-game at score 12 -> outputs clear to 0 and IDLE before the next clk edge. An apple in IDLE does not count.
6. With SNAKE_SCORE_HIGH_SCORE_EN:
   - Play to score 7, collide, restart, play to 3, collide.
   - show_best=1 -> score_code=7'b0011100.
   - show_best=0 -> score_code=7'b0001100.

Source files
------------

// File: rtl/snake_score.sv
// snake_score: apple-event score counter and game-state controller for the
// snake game. Feeds {score, 2'b00} to the downstream two-digit 7-segment
// transcoder.
// Optional feature macro: SNAKE_SCORE_HIGH_SCORE_EN (best-score register and
// show_best input). With the macro undefined, score_code always shows the live
// score.
module snake_score #(
  parameter int unsigned MAX_SCORE    = 31,
  parameter int unsigned APPLE_POINTS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       apple,
  input  logic       collision,
`ifdef SNAKE_SCORE_HIGH_SCORE_EN
  input  logic       show_best,
`endif
  output logic [6:0] score_code,
  output logic       running,
  output logic       game_over,
  output logic       win
);

  localparam int unsigned SCORE_W = 5;
  localparam int unsigned SUM_W   = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2,
    WIN  = 2'd3
  } state_t;

  localparam logic [SCORE_W-1:0] MAX_Q = SCORE_W'(MAX_SCORE);
  localparam logic [SUM_W-1:0]   MAX_S = SUM_W'(MAX_SCORE);
  localparam logic [SUM_W-1:0]   PTS_S = SUM_W'(APPLE_POINTS);

  state_t               state;
  logic [SCORE_W-1:0]   score;
  logic                 apple_q;
  logic                 rise;
  logic [SUM_W-1:0]     sum;
  logic                 hit_max;

  // One apple event per 0->1 transition of the apple level.
  assign rise    = apple & ~apple_q;
  // Six-bit sum so adding points to a near-max score cannot wrap.
  assign sum     = SUM_W'(score) + PTS_S;
  assign hit_max = (sum >= MAX_S);

  // Apple level history, sampled every cycle regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apple_q <= 1'b0;
    end else begin
      apple_q <= apple;
    end
  end

  // Game FSM and score register; collision outranks an apple on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      score <= '0;
    end else begin
      case (state)
        IDLE, OVER, WIN: begin
          if (start) begin
            state <= RUN;
            score <= '0;
          end
        end
        RUN: begin
          if (collision) begin
            state <= OVER;
          end else if (rise) begin
            if (hit_max) begin
              score <= MAX_Q;
              state <= WIN;
            end else begin
              score <= sum[SCORE_W-1:0];
            end
          end
        end
        default: begin
          state <= IDLE;
          score <= '0;
        end
      endcase
    end
  end

  // Flags decode straight from the registered state.
  assign running   = (state == RUN);
  assign game_over = (state == OVER);
  assign win       = (state == WIN);

`ifdef SNAKE_SCORE_HIGH_SCORE_EN
  logic [SCORE_W-1:0] best;
  logic               show_best_q;

  // Best score captured on each entry into OVER or WIN; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best <= '0;
    end else if (state == RUN) begin
      if (collision) begin
        if (score > best) begin
          best <= score;
        end
      end else if (rise && hit_max) begin
        if (MAX_Q > best) begin
          best <= MAX_Q;
        end
      end
    end
  end

  // show_best is registered so score_code has no combinational input path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      show_best_q <= 1'b0;
    end else begin
      show_best_q <= show_best;
    end
  end

  assign score_code = (show_best_q && (state != RUN)) ? {best, 2'b00}
                                                      : {score, 2'b00};
`else
  assign score_code = {score, 2'b00};
`endif

endmodule

// File: tb/tb_snake_score.sv
// Self-checking bench for snake_score (default parameters). Table of single-
// cycle vectors plus hand sequences for held apple, saturation, async reset
// and, when SNAKE_SCORE_HIGH_SCORE_EN is defined, the best-score display.
module tb_snake_score;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       apple;
  logic       collision;
  logic [6:0] score_code;
  logic       running;
  logic       game_over;
  logic       win;
`ifdef SNAKE_SCORE_HIGH_SCORE_EN
  logic       show_best;
`endif

  snake_score #(.MAX_SCORE(31), .APPLE_POINTS(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .apple      (apple),
    .collision  (collision),
`ifdef SNAKE_SCORE_HIGH_SCORE_EN
    .show_best  (show_best),
`endif
    .score_code (score_code),
    .running    (running),
    .game_over  (game_over),
    .win        (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] code;
    logic       run;
    logic       over;
    logic       won;
  } exp_t;

  typedef struct packed {
    logic s;
    logic a;
    logic c;
    exp_t e;
  } vec_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  function automatic exp_t mk(input logic [6:0] code, input logic r,
                              input logic o, input logic w);
    exp_t e;
    e.code = code; e.run = r; e.over = o; e.won = w;
    return e;
  endfunction

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic compare_pop();
    exp_t  e;
    exp_t  got;
    string nm;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty");
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    got = mk(score_code, running, game_over, win);
    n_total++;
    if (got === e) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got code=%b run=%b over=%b win=%b, want code=%b run=%b over=%b win=%b",
               nm, got.code, got.run, got.over, got.won,
               e.code, e.run, e.over, e.won);
    end
  endtask

  // Drive one cycle of inputs (called just after a negedge), check after posedge.
  task automatic step(input logic s, input logic a, input logic c,
                      input exp_t e, input string nm);
    start = s; apple = a; collision = c;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    compare_pop();
    @(negedge clk);
  endtask

  // Apple pulse: one high cycle then one low cycle, both expecting the same view.
  task automatic pulse(input exp_t e, input string nm);
    step(1'b0, 1'b1, 1'b0, e, nm);
    step(1'b0, 1'b0, 1'b0, e, nm);
  endtask

  vec_t  vt[9];
  string vn[9];

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; apple = 1'b0; collision = 1'b0;
`ifdef SNAKE_SCORE_HIGH_SCORE_EN
    show_best = 1'b0;
`endif

    // Reset, apple ignored in IDLE, start, three separate apples.
    vt[0] = '{1'b0, 1'b0, 1'b0, mk(7'd0,  1'b0, 1'b0, 1'b0)}; vn[0] = "idle_hold";
    vt[1] = '{1'b0, 1'b1, 1'b0, mk(7'd0,  1'b0, 1'b0, 1'b0)}; vn[1] = "idle_apple_ignored";
    vt[2] = '{1'b1, 1'b0, 1'b0, mk(7'd0,  1'b1, 1'b0, 1'b0)}; vn[2] = "start_run";
    vt[3] = '{1'b0, 1'b1, 1'b0, mk(7'd4,  1'b1, 1'b0, 1'b0)}; vn[3] = "apple1";
    vt[4] = '{1'b0, 1'b0, 1'b0, mk(7'd4,  1'b1, 1'b0, 1'b0)}; vn[4] = "apple1_low";
    vt[5] = '{1'b0, 1'b1, 1'b0, mk(7'd8,  1'b1, 1'b0, 1'b0)}; vn[5] = "apple2";
    vt[6] = '{1'b1, 1'b0, 1'b0, mk(7'd8,  1'b1, 1'b0, 1'b0)}; vn[6] = "start_ignored_in_run";
    vt[7] = '{1'b0, 1'b1, 1'b0, mk(7'd12, 1'b1, 1'b0, 1'b0)}; vn[7] = "apple3";
    vt[8] = '{1'b0, 1'b0, 1'b0, mk(7'd12, 1'b1, 1'b0, 1'b0)}; vn[8] = "apple3_low";

    #3;
    exp_q.push_back(mk(7'd0, 1'b0, 1'b0, 1'b0));
    name_q.push_back("reset_state");
    compare_pop();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(vt[i].s, vt[i].a, vt[i].c, vt[i].e, vn[i]);
    end

    // Apple held for ten cycles counts once: 3 -> 4.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, mk(7'd16, 1'b1, 1'b0, 1'b0), "apple_held");
    end
    step(1'b0, 1'b0, 1'b0, mk(7'd16, 1'b1, 1'b0, 1'b0), "apple_held_release");
    pulse(mk(7'd20, 1'b1, 1'b0, 1'b0), "apple_to_5");

    // Collision and apple rise together: collision wins, score frozen at 5.
    step(1'b0, 1'b1, 1'b1, mk(7'd20, 1'b0, 1'b1, 1'b0), "collide_with_apple");
    step(1'b0, 1'b0, 1'b0, mk(7'd20, 1'b0, 1'b1, 1'b0), "over_hold");
    pulse(mk(7'd20, 1'b0, 1'b1, 1'b0), "over_apple_ignored");
    step(1'b0, 1'b0, 1'b1, mk(7'd20, 1'b0, 1'b1, 1'b0), "over_collision_ignored");

    // Restart together with collision from OVER, then saturate at 31.
    step(1'b1, 1'b0, 1'b1, mk(7'd0, 1'b1, 1'b0, 1'b0), "restart_with_collision");
    for (int i = 1; i <= 31; i++) begin
      pulse(mk(7'(i << 2), (i < 31) ? 1'b1 : 1'b0, 1'b0, (i == 31) ? 1'b1 : 1'b0),
            "count_to_max");
    end
    pulse(mk(7'b1111100, 1'b0, 1'b0, 1'b1), "win_apple_ignored");
    step(1'b0, 1'b0, 1'b1, mk(7'b1111100, 1'b0, 1'b0, 1'b1), "win_collision_ignored");
    step(1'b1, 1'b0, 1'b0, mk(7'd0, 1'b1, 1'b0, 1'b0), "restart_from_win");

    // Async reset mid-game at score 12 clears before the next clock edge.
    for (int i = 1; i <= 12; i++) begin
      pulse(mk(7'(i << 2), 1'b1, 1'b0, 1'b0), "count_to_12");
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(7'd0, 1'b0, 1'b0, 1'b0));
    name_q.push_back("async_reset_clear");
    compare_pop();
    @(negedge clk);
    rst_n = 1'b1;
    pulse(mk(7'd0, 1'b0, 1'b0, 1'b0), "idle_apple_after_reset");
    step(1'b1, 1'b0, 1'b0, mk(7'd0, 1'b1, 1'b0, 1'b0), "start_after_reset");
    pulse(mk(7'd4, 1'b1, 1'b0, 1'b0), "apple_after_reset");

`ifdef SNAKE_SCORE_HIGH_SCORE_EN
    // Best score survives restarts; show_best selects it outside RUN.
    step(1'b1, 1'b0, 1'b1, mk(7'd4, 1'b0, 1'b1, 1'b0), "hs_collide_1");
    step(1'b1, 1'b0, 1'b0, mk(7'd0, 1'b1, 1'b0, 1'b0), "hs_start_a");
    for (int i = 1; i <= 7; i++) begin
      pulse(mk(7'(i << 2), 1'b1, 1'b0, 1'b0), "hs_play_7");
    end
    step(1'b0, 1'b0, 1'b1, mk(7'd28, 1'b0, 1'b1, 1'b0), "hs_collide_7");
    step(1'b1, 1'b0, 1'b0, mk(7'd0, 1'b1, 1'b0, 1'b0), "hs_restart");
    show_best = 1'b1;
    pulse(mk(7'd4, 1'b1, 1'b0, 1'b0), "hs_run_shows_live");
    show_best = 1'b0;
    for (int i = 2; i <= 3; i++) begin
      pulse(mk(7'(i << 2), 1'b1, 1'b0, 1'b0), "hs_play_3");
    end
    step(1'b0, 1'b0, 1'b1, mk(7'd12, 1'b0, 1'b1, 1'b0), "hs_collide_3");
    show_best = 1'b1;
    step(1'b0, 1'b0, 1'b0, mk(7'b0011100, 1'b0, 1'b1, 1'b0), "hs_show_best");
    show_best = 1'b0;
    step(1'b0, 1'b0, 1'b0, mk(7'b0001100, 1'b0, 1'b1, 1'b0), "hs_show_live");
`endif

    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
